// File: rtl/alu_pkg.sv
// Shared op encodings and types for the pipelined execute ALU.
package alu_pkg;

  typedef logic [2:0] op_t;

  // Op[2]=0 selects the shifter, Op[2]=1 the adder/logic group.
  localparam op_t OP_ROTL = 3'b000;
  localparam op_t OP_SHL  = 3'b001;
  localparam op_t OP_ROTR = 3'b010;
  localparam op_t OP_SHR  = 3'b011;
  localparam op_t OP_ADD  = 3'b100;
  localparam op_t OP_OR   = 3'b101;
  localparam op_t OP_XOR  = 3'b110;
  localparam op_t OP_AND  = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: rotate left/right and logical shift left/right.
module alu_shifter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out
);

  localparam logic [1:0] SEL_ROTL = OP_ROTL[1:0];
  localparam logic [1:0] SEL_SHL  = OP_SHL[1:0];
  localparam logic [1:0] SEL_ROTR = OP_ROTR[1:0];

  // Shifting by WIDTH yields zero, so count 0 makes both rotates pass In through.
  logic [WIDTH-1:0] rotl_w;
  logic [WIDTH-1:0] rotr_w;

  // Select one of the four shift flavours.
  always_comb begin
    // NOTE: assign every always_comb output before the case so no path leaves it unassigned (latch).
    Out    = In >> Cnt;
    rotl_w = (In << Cnt) | (In >> (WIDTH - int'(Cnt)));
    rotr_w = (In >> Cnt) | (In << (WIDTH - int'(Cnt)));
    case (Op)
      SEL_ROTL: Out = rotl_w;
      SEL_SHL:  Out = In << Cnt;
      SEL_ROTR: Out = rotr_w;
      default:  Out = In >> Cnt;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined execute ALU with valid/ready handshakes on both sides.
// S1 captures the (optionally inverted) operands; S2 holds the result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Cout,
  output logic             Neg,
  output logic             Z
);

  localparam int SHW = $clog2(WIDTH);

  logic             s1_valid;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  op_t              s1_op;
  logic             s1_sign;

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res_d;
  logic             ofl_d;
  logic             cout_d;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Stage valid bits: the only pipeline state that must be reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
    end
  end

  // S1 operand capture; loads only on an accepted bundle to avoid needless toggling.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid bit guards them and is reset instead.
    if (!rst && in_valid && adv1) begin
      s1_a    <= invA ? ~A : A;
      s1_b    <= invB ? ~B : B;
      s1_cin  <= Cin;
      s1_op   <= Op;
      s1_sign <= sign;
    end
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .In  (s1_a),
    .Cnt (s1_b[SHW-1:0]),
    .Op  (s1_op[1:0]),
    .Out (shift_res)
  );

  // Execute: full-width add with carry, bitwise ops, shifter result, overflow.
  always_comb begin
    sum_ext = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
    res_d   = shift_res;
    ofl_d   = 1'b0;
    cout_d  = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_d  = sum_ext[WIDTH-1:0];
        cout_d = sum_ext[WIDTH];
        ofl_d  = s1_sign ? ((s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != s1_a[WIDTH-1]))
                         : sum_ext[WIDTH];
      end
      OP_OR:   res_d = s1_a | s1_b;
      OP_XOR:  res_d = s1_a ^ s1_b;
      OP_AND:  res_d = s1_a & s1_b;
      default: res_d = shift_res;
    endcase
  end

  // S2 result register; holds bit-stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out  <= '0;
      Ofl  <= 1'b0;
      Cout <= 1'b0;
      Neg  <= 1'b0;
      Z    <= 1'b1;
    end else if (s1_valid && adv2) begin
      Out  <= res_d;
      Ofl  <= ofl_d;
      Cout <= cout_d;
      Neg  <= res_d[WIDTH-1];
      Z    <= (res_d == '0);
    end
  end

endmodule
